// File: rtl/cla_pkg.sv
// Shared definitions for the CLA issue/collect controller.
package cla_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LAT   = 4;

    // Controller states; encoding is fixed so it can be probed by name.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Hold counter must be able to reach LAT.
    function automatic int cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/opnd_fifo.sv
// Operand-pair FIFO: entry = {a, b}, registered pointers, no fall-through.
module opnd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [2*WIDTH-1:0] din,
    output logic [2*WIDTH-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Storage: written on push only, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/cla_issue_ctrl.sv
// Issue/collect wrapper for the pipelined CLA: queues operand pairs, holds
// one pair on the adder for the carry-pipeline depth, captures the sum.
module cla_issue_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int CNT_W = cnt_w(LAT);
    localparam int CW    = $clog2(DEPTH + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   add_a_q, add_b_q;
    logic [WIDTH:0]     out_sum_q;
    logic               out_valid_q;

    logic               push, load;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt;
    logic [2*WIDTH-1:0] head;
    logic               unused_fifo_cnt;

    // Occupancy is tracked via full/empty only.
    assign unused_fifo_cnt = ^fifo_cnt;

    // No bypass: a same-cycle pop never opens a slot for a push.
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;

    // A new pair goes onto the adder from IDLE, or from DONE as the result leaves.
    assign load = !fifo_empty &&
                  ((state_q == IDLE) || ((state_q == DONE) && out_ready));

    opnd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .din   ({in_a, in_b}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;

    // Issue FSM: load a pair, wait LAT+1 edges for the carry tree, capture, hand off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (load) begin
                add_a_q <= head[2*WIDTH-1:WIDTH];
                add_b_q <= head[WIDTH-1:0];
            end
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(LAT)) begin
                        out_sum_q   <= add_s;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= load ? HOLD : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
